// File: rtl/cpp_mul_8x8_if.sv
// Operand/product bundle for the 8x8 unsigned array multiplier.
// The master drives operands and observes the registered product;
// the slave (the multiplier) does the reverse.
interface cpp_mul_8x8_if;
    logic [7:0]  mcand;
    logic [7:0]  mplr;
    logic        in_valid;
    logic [15:0] prod;
    logic        out_valid;

    modport master (
        output mcand,
        output mplr,
        output in_valid,
        input  prod,
        input  out_valid
    );

    modport slave (
        input  mcand,
        input  mplr,
        input  in_valid,
        output prod,
        output out_valid
    );
endinterface

// File: rtl/cpp_mul_8x8.sv
// 8x8 unsigned carry-propagate array multiplier with a registered 16-bit
// product and one cycle of latency. The core is built from explicit
// half-adder and full-adder cells arranged in rows; each row ripples its
// carry along the row and hands its carry-out to the next row.
module cpp_mul_8x8 (
    input  logic                clk,
    input  logic                rst,
    cpp_mul_8x8_if.slave        bus
);

    // Partial products: pp_s[i][j] = mcand[j] & mplr[i]
    logic [7:0][7:0] pp_s;
    // Row sums; sum_s[i][0] is the settled product bit i
    logic [7:0][7:0] sum_s;
    // Per-cell carry-outs for rows 1..7; carry_s[i][7] is the row carry-out
    logic [7:1][7:0] carry_s;
    logic [15:0]     prod_d;
    logic [15:0]     prod_q;
    logic            out_valid_d;
    logic            out_valid_q;

    genvar gi, gj;

    // AND-gate partial product matrix
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pp_row
            for (gj = 0; gj < 8; gj++) begin : g_pp_col
                assign pp_s[gi][gj] = bus.mcand[gj] & bus.mplr[gi];
            end
        end
    endgenerate

    // Row 0 is the bare first partial product
    assign sum_s[0] = pp_s[0];

    // Rows 1..7: add pp[i] to the running sum shifted down one place.
    // The addend from the previous row is its sum bits 7:1 with its
    // carry-out on top (row 0 has no carry-out, so a zero fills that slot).
    generate
        for (gi = 1; gi < 8; gi++) begin : g_row
            logic [7:0] addend_s;

            if (gi == 1) begin : g_first
                assign addend_s = {1'b0, sum_s[0][7:1]};
            end else begin : g_rest
                assign addend_s = {carry_s[gi-1][7], sum_s[gi-1][7:1]};
            end

            // Half adder at the LSB of the row
            assign sum_s[gi][0]   = pp_s[gi][0] ^ addend_s[0];
            assign carry_s[gi][0] = pp_s[gi][0] & addend_s[0];

            // Ripple chain of full adders for the remaining columns
            for (gj = 1; gj < 8; gj++) begin : g_fa
                logic axb_s;
                assign axb_s           = pp_s[gi][gj] ^ addend_s[gj];
                assign sum_s[gi][gj]   = axb_s ^ carry_s[gi][gj-1];
                assign carry_s[gi][gj] = (pp_s[gi][gj] & addend_s[gj]) |
                                         (axb_s & carry_s[gi][gj-1]);
            end
        end
    endgenerate

    // Gather the product: one settled LSB per row, then the final row's
    // upper sum bits, then its ripple carry-out as the MSB.
    always_comb begin
        prod_d = 16'h0000;
        for (int k = 0; k < 8; k++) begin
            prod_d[k] = sum_s[k][0];
        end
        prod_d[14:8] = sum_s[7][7:1];
        prod_d[15]   = carry_s[7][7];
    end

    assign out_valid_d = bus.in_valid;

    // Output register: product updates every edge, valid tracks in_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q      <= 16'h0000;
            out_valid_q <= 1'b0;
        end else begin
            prod_q      <= prod_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.prod      = prod_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_cpp_mul_8x8.sv
// Scoreboard bench for cpp_mul_8x8: the driver pushes the expected
// response for every cycle it drives; a separate monitor pops and compares
// shortly after each rising edge.
module tb_cpp_mul_8x8;

    logic clk;
    logic rst;

    cpp_mul_8x8_if bus ();

    cpp_mul_8x8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic        v;
        logic [15:0] p;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus (between edges) and record the response
    // expected right after the next rising edge.
    task automatic apply(input logic r, input logic [7:0] a, input logic [7:0] b,
                         input logic v, input logic [15:0] exp_p);
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.mcand    = a;
        bus.mplr     = b;
        bus.in_valid = v;
        e.v = r ? 1'b0 : v;
        e.p = r ? 16'h0000 : exp_p;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the DUT output against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.out_valid !== e.v || bus.prod !== e.p) begin
                    failures++;
                    $display("FAIL result @%0t: got valid=%0b prod=%h, expected valid=%0b prod=%h",
                             $time, bus.out_valid, bus.prod, e.v, e.p);
                end
            end
        end
    end

    initial begin
        rst          = 1'b1;
        bus.mcand    = 8'h00;
        bus.mplr     = 8'h00;
        bus.in_valid = 1'b0;

        // Reset held for two cycles with live operands
        apply(1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0000);
        apply(1'b1, 8'hFF, 8'hFF, 1'b1, 16'h0000);
        apply(1'b0, 8'hFF, 8'hFF, 1'b1, 16'hFE01);

        // mcand = 0xFF
        apply(1'b0, 8'hFF, 8'h00, 1'b1, 16'h0000);
        apply(1'b0, 8'hFF, 8'h01, 1'b1, 16'h00FF);
        apply(1'b0, 8'hFF, 8'h10, 1'b1, 16'h0FF0);
        apply(1'b0, 8'hFF, 8'h11, 1'b1, 16'h10EF);
        // mcand = 0x03
        apply(1'b0, 8'h03, 8'h00, 1'b1, 16'h0000);
        apply(1'b0, 8'h03, 8'h01, 1'b1, 16'h0003);
        apply(1'b0, 8'h03, 8'h10, 1'b1, 16'h0030);
        apply(1'b0, 8'h03, 8'h11, 1'b1, 16'h0033);
        // mcand = 0xAA
        apply(1'b0, 8'hAA, 8'h00, 1'b1, 16'h0000);
        apply(1'b0, 8'hAA, 8'h01, 1'b1, 16'h00AA);
        apply(1'b0, 8'hAA, 8'h10, 1'b1, 16'h0AA0);
        apply(1'b0, 8'hAA, 8'h11, 1'b1, 16'h0B4A);
        // mcand = 0x55
        apply(1'b0, 8'h55, 8'h00, 1'b1, 16'h0000);
        apply(1'b0, 8'h55, 8'h01, 1'b1, 16'h0055);
        apply(1'b0, 8'h55, 8'h10, 1'b1, 16'h0550);
        apply(1'b0, 8'h55, 8'h11, 1'b1, 16'h05A5);
        // Operand 1 on the multiplicand side, zero on the multiplier side
        apply(1'b0, 8'h01, 8'hC3, 1'b1, 16'h00C3);
        apply(1'b0, 8'hC3, 8'h00, 1'b1, 16'h0000);
        // in_valid toggling: product updates regardless, valid lags by one
        apply(1'b0, 8'h12, 8'h34, 1'b1, 16'h03A8);
        apply(1'b0, 8'h80, 8'h80, 1'b0, 16'h4000);
        apply(1'b0, 8'h80, 8'h80, 1'b1, 16'h4000);
        // Reset mid-stream discards the in-flight result
        apply(1'b1, 8'h7F, 8'h7F, 1'b1, 16'h0000);
        apply(1'b0, 8'h7F, 8'h7F, 1'b1, 16'h3F01);

        // Exhaustive back-to-back sweep with a reset dropped in mid-way
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                if (a == 100 && b == 37) begin
                    apply(1'b1, 8'(a), 8'(b), 1'b1, 16'h0000);
                end
                apply(1'b0, 8'(a), 8'(b), 1'b1, 16'(a * b));
            end
        end

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending results, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpp_mul_8x8.md
Name: cpp_mul_8x8

Overview:
- 8x8 unsigned carry-propagate array multiplier with a registered 16-bit product.
- The core is a structural array: 64 AND-gate partial products reduced by rows of full/half adders. Each row ripples its carry into the next row (carry-propagate rows).
- Used as a leaf arithmetic block in datapaths that need a one-cycle-latency unsigned 8-bit multiply.

Parameters:
- none (widths fixed: 8-bit operands, 16-bit product)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- mcand  input  8  multiplicand, unsigned
- mplr  input  8  multiplier, unsigned
- in_valid  input  1  operands on mcand/mplr are valid this cycle
- prod  output  16  registered product mcand*mplr, unsigned
- out_valid  output  1  prod holds the result of an in_valid cycle

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - On a rising clk edge with rst=1: prod <= 16'h0000 and out_valid <= 0.
  - rst has priority over every other input.
  - Reset mid-operation discards the in-flight result.
- Combinational core:
  - pp[i][j] = mcand[j] & mplr[i].
  - Row 0 is pp[0].
  - Each subsequent row i adds pp[i] (shifted left by i) to the running sum using a ripple chain of full adders, with a half adder at the LSB position.
  - The final row's ripple carry-out forms prod[15].
  - Built from explicit half-adder and full-adder cells (submodules or generate loops). No behavioural "*" operator in the core.
- Arithmetic:
  - Pure unsigned multiply; result is exact in 16 bits (max 0xFF*0xFF = 0xFE01). No overflow or truncation.
- Timing and latency:
  - 1 cycle: operands sampled at rising edge N appear on prod immediately after edge N.
  - out_valid <= in_valid each non-reset edge.
- Product update policy:
  - prod updates every non-reset edge regardless of in_valid. prod is therefore always the product of the operands present at the last edge.
  - out_valid alone qualifies prod.
  - There is no stall or backpressure. Back-to-back operands are accepted every cycle, one result per cycle.
- Boundary conditions:
  - Either operand 0 -> prod 0.
  - Operand 1 -> prod = the other operand, zero-extended.
  - Operands that change between edges have no effect until the next edge.
- No X propagation from the core when inputs are known; all outputs are known after the first reset edge.

Test Plan:
- Assert rst for 2 cycles with mcand=0xFF, mplr=0xFF, in_valid=1 -> prod=0x0000 and out_valid=0 during reset. One cycle after release: prod=0xFE01, out_valid=1.
- mcand=0xFF with mplr = 0x00, 0x01, 0x10, 0x11 on consecutive cycles, in_valid=1 -> prod = 0x0000, 0x00FF, 0x0FF0, 0x10EF, each one cycle after the operands are applied.
- mcand=0x03 with mplr = 0x00, 0x01, 0x10, 0x11 -> prod = 0x0000, 0x0003, 0x0030, 0x0033.
- mcand=0xAA, then 0x55, each with mplr = 0x00, 0x01, 0x10, 0x11:
  - 0xAA -> prod = 0x0000, 0x00AA, 0x0AA0, 0x0B4A.
  - 0x55 -> prod = 0x0000, 0x0055, 0x0550, 0x05A5.
- Toggle in_valid 1,0,1 with changing operands (0x12*0x34, then 0x80*0x80) -> out_valid follows in_valid one cycle late; prod = 0x03A8, then 0x4000.
- Exhaustive sweep of all 65,536 operand pairs against a golden model (a*b), back-to-back with no stall -> zero mismatches. Include rst asserted mid-sweep: prod=0 and out_valid=0 on the next edge, then correct results resume.
